// File: rtl/x_uart_tx.sv
// x_uart_tx: byte-wide UART transmitter.
// Takes one byte per valid/accept handshake and sends it on a single line
// as one start bit, 8 data bits LSB-first and STOP_BITS stop bits. Each bit
// lasts CLKS_PER_BIT core clocks. The serial line and the busy flag come from
// flops, so both are glitch-free.
module x_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_accept,
    output logic       o_tx,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    state_t        state_r, state_s;
    logic [7:0]    shift_r, shift_s;
    logic [BW-1:0] baud_r,  baud_s;
    logic [2:0]    bit_r,   bit_s;
    logic          tx_r,    tx_s;
    logic          busy_r,  busy_s;
    logic          accept_s;
    logic          baud_wrap_s;

    // Next-state, next-register values and the accept strobe for the frame sequencer.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        baud_s      = baud_r;
        bit_s       = bit_r;
        tx_s        = tx_r;
        accept_s    = 1'b0;
        baud_wrap_s = (baud_r == BAUD_LAST);

        case (state_r)
            IDLE: begin
                tx_s   = 1'b1;
                baud_s = {BW{1'b0}};
                if (i_valid) begin
                    // The start bit appears on the line in the cycle after the accept.
                    accept_s = 1'b1;
                    shift_s  = i_data;
                    bit_s    = 3'd0;
                    tx_s     = 1'b0;
                    state_s  = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_wrap_s) begin
                    baud_s  = {BW{1'b0}};
                    bit_s   = 3'd0;
                    tx_s    = shift_r[0];
                    state_s = DATA;
                end else begin
                    baud_s = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (baud_wrap_s) begin
                    baud_s  = {BW{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        tx_s    = 1'b1;
                        state_s = STOP;
                    end else begin
                        // Present the bit that becomes shift[0] after this shift.
                        bit_s = bit_r + 3'd1;
                        tx_s  = shift_r[1];
                    end
                end else begin
                    baud_s = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            STOP: begin
                tx_s = 1'b1;
                if (baud_wrap_s) begin
                    baud_s = {BW{1'b0}};
                    if (bit_r == STOP_LAST) begin
                        bit_s   = 3'd0;
                        state_s = IDLE;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                tx_s    = 1'b1;
                baud_s  = {BW{1'b0}};
                bit_s   = 3'd0;
            end
        endcase

        // Busy is registered from the next state so it lines up with state_r.
        busy_s = (state_s != IDLE);
    end

    // Sequencer registers: state, shifter, baud/bit counters, line and busy flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            shift_r <= 8'h00;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
        end
    end

    assign o_accept = accept_s;
    assign o_tx     = tx_r;
    assign o_busy   = busy_r;

endmodule
